// File: rtl/axi_tx_pkt_fifo.sv
// -----------------------------------------------------------------------------
// axi_tx_pkt_fifo
//
// Egress AXI-Stream transmitter. Beats from the action stage are written into a
// store-and-forward packet FIFO. A packet becomes readable only after its last
// beat has been written and committed. Packets flagged with in_drop on their
// last beat, and packets longer than DEPTH beats, are discarded. Committed
// packets are sent out on a master AXI-Stream port through a prefetching output
// register.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active-high
//   in_valid    in   action-stage beat valid
//   in_data     in   beat data            [DATA_WIDTH]
//   in_keep     in   byte enables         [DATA_WIDTH/8]
//   in_last     in   last beat of packet
//   in_drop     in   discard request, only meaningful together with in_last
//   in_ready    out  beat accepted when in_valid && in_ready
//   tx_tvalid   out  master AXIS valid
//   tx_tdata    out  master AXIS data     [DATA_WIDTH]
//   tx_tkeep    out  master AXIS keep     [DATA_WIDTH/8]
//   tx_tlast    out  master AXIS last
//   tx_tready   in   downstream ready
//   tx_pkt_cnt  out  packets fully transmitted          [CNT_WIDTH]
//   drop_cnt    out  packets discarded (drop/oversize)  [CNT_WIDTH]
//   occupancy   out  wr_ptr - rd_ptr in beats           [AW+1]
// -----------------------------------------------------------------------------
module axi_tx_pkt_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [DATA_WIDTH/8-1:0]    in_keep,
  input  logic                       in_last,
  input  logic                       in_drop,
  output logic                       in_ready,
  output logic                       tx_tvalid,
  output logic [DATA_WIDTH-1:0]      tx_tdata,
  output logic [DATA_WIDTH/8-1:0]    tx_tkeep,
  output logic                       tx_tlast,
  input  logic                       tx_tready,
  output logic [CNT_WIDTH-1:0]       tx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]       drop_cnt,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int MW = DATA_WIDTH + KW + 1;   // {last, keep, data}
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IN_PKT,
    S_DISCARD
  } state_t;

  // Beat storage, one entry per beat.
  logic [MW-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] commit_ptr_q, commit_ptr_d;
  logic [AW:0] rd_ptr_q;

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0] tx_pkt_cnt_q;

  logic                 tx_tvalid_q;
  logic [DATA_WIDTH-1:0] tx_tdata_q;
  logic [KW-1:0]        tx_tkeep_q;
  logic                 tx_tlast_q;

  logic [AW:0] fill_level;
  logic [AW:0] pkt_len_next;
  logic        full;
  logic        accept;
  logic        mem_we;
  logic        commit_avail;
  logic        out_adv;

  // fill_level and full come from registered pointers only, so a read in this
  // cycle frees space for the writer one cycle later and tx_tready never
  // reaches in_ready combinationally.
  assign fill_level   = wr_ptr_q - rd_ptr_q;
  assign full         = (fill_level == DEPTH_P);
  // Length of the current packet if the beat offered now were stored.
  assign pkt_len_next = wr_ptr_q + 1'b1 - commit_ptr_q;

  assign in_ready = !rst && ((state_q == S_DISCARD) || !full);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Write FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_cnt_d   = drop_cnt_q;
    mem_we       = 1'b0;

    case (state_q)
      S_IDLE, S_IN_PKT: begin
        if (accept) begin
          // The slot at wr_ptr is always free here (not full), so writing it
          // is harmless even when the packet is about to be rewound.
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (in_last) begin
            state_d = S_IDLE;
            if (in_drop) begin
              wr_ptr_d   = commit_ptr_q;
              drop_cnt_d = drop_cnt_q + 1'b1;
            end else begin
              commit_ptr_d = wr_ptr_q + 1'b1;
            end
          end else if (pkt_len_next == DEPTH_P) begin
            // A non-last beat filling a whole FIFO's worth: the packet can
            // never be committed, so rewind now and swallow the rest.
            wr_ptr_d   = commit_ptr_q;
            drop_cnt_d = drop_cnt_q + 1'b1;
            state_d    = S_DISCARD;
          end else begin
            state_d = S_IN_PKT;
          end
        end
      end

      S_DISCARD: begin
        if (accept && in_last) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= {in_last, in_keep, in_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: prefetching output register
  // ---------------------------------------------------------------------------
  assign commit_avail = (rd_ptr_q != commit_ptr_q);
  assign out_adv      = !tx_tvalid_q || tx_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      tx_tvalid_q  <= 1'b0;
      tx_tdata_q   <= '0;
      tx_tkeep_q   <= '0;
      tx_tlast_q   <= 1'b0;
      tx_pkt_cnt_q <= '0;
    end else begin
      if (out_adv) begin
        if (commit_avail) begin
          {tx_tlast_q, tx_tkeep_q, tx_tdata_q} <= mem[rd_ptr_q[AW-1:0]];
          rd_ptr_q    <= rd_ptr_q + 1'b1;
          tx_tvalid_q <= 1'b1;
        end else begin
          tx_tvalid_q <= 1'b0;
        end
      end
      if (tx_tvalid_q && tx_tready && tx_tlast_q) begin
        tx_pkt_cnt_q <= tx_pkt_cnt_q + 1'b1;
      end
    end
  end

  assign tx_tvalid  = tx_tvalid_q;
  assign tx_tdata   = tx_tdata_q;
  assign tx_tkeep   = tx_tkeep_q;
  assign tx_tlast   = tx_tlast_q;
  assign tx_pkt_cnt = tx_pkt_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign occupancy  = fill_level;

endmodule

// File: tb/tb_axi_tx_pkt_fifo.sv
module tb_axi_tx_pkt_fifo;
  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int CW    = 32;
  localparam int KW    = DW / 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [KW-1:0] in_keep = '0;
  logic          in_last = 1'b0;
  logic          in_drop = 1'b0;
  logic          in_ready;
  logic          tx_tvalid;
  logic [DW-1:0] tx_tdata;
  logic [KW-1:0] tx_tkeep;
  logic          tx_tlast;
  logic          tx_tready = 1'b0;
  logic [CW-1:0] tx_pkt_cnt;
  logic [CW-1:0] drop_cnt;
  logic [AW:0]   occupancy;

  always #5 clk = ~clk;

  axi_tx_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep),
    .in_last(in_last), .in_drop(in_drop), .in_ready(in_ready),
    .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep),
    .tx_tlast(tx_tlast), .tx_tready(tx_tready),
    .tx_pkt_cnt(tx_pkt_cnt), .drop_cnt(drop_cnt), .occupancy(occupancy)
  );

  // Reference model: packets are collected whole; a finished packet that is
  // neither flagged nor longer than DEPTH is appended to the expected stream.
  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    int len;
    bit drop;
    int tmode;
    int exp_drop_inc;
    int exp_tx_inc;
    int exp_stall;
  } vec_t;

  beat_t exp_q[$];
  beat_t cur_pkt[$];
  bit    discarding = 1'b0;
  int    exp_tx = 0;
  int    exp_drop = 0;

  int n_checks = 0;
  int n_errors = 0;

  // Driver state
  logic          drv_valid = 1'b0;
  logic [DW-1:0] drv_data = '0;
  logic [KW-1:0] drv_keep = '0;
  logic          drv_last = 1'b0;
  logic          drv_drop = 1'b0;
  logic          drv_tready = 1'b1;
  int            tr_mode = 0;   // 0: ready, 1: toggle, 2: stalled, 3: random

  bit    acc;
  bit    hs;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;
  int    stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_accept();
    beat_t b;
    b.data = in_data;
    b.keep = in_keep;
    b.last = in_last;
    if (discarding) begin
      if (in_last) discarding = 1'b0;
    end else begin
      cur_pkt.push_back(b);
      if (in_last) begin
        if (in_drop) exp_drop++;
        else foreach (cur_pkt[k]) exp_q.push_back(cur_pkt[k]);
        cur_pkt.delete();
      end else if (cur_pkt.size() == DEPTH) begin
        exp_drop++;
        cur_pkt.delete();
        discarding = 1'b1;
      end
    end
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, and account for
  // the handshakes that the next rising edge will complete.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    case (tr_mode)
      0:       drv_tready = 1'b1;
      1:       drv_tready = ~drv_tready;
      2:       drv_tready = 1'b0;
      default: drv_tready = 1'($urandom_range(0, 1));
    endcase
    in_valid  = drv_valid;
    in_data   = drv_data;
    in_keep   = drv_keep;
    in_last   = drv_last;
    in_drop   = drv_drop;
    tx_tready = drv_tready;
    #1;
    acc = in_valid && in_ready;
    hs  = tx_tvalid && tx_tready;
    if (prev_stall) begin
      chk("axis_hold_valid", tx_tvalid, 1);
      chk("axis_hold_data", tx_tdata, prev_beat.data);
      chk("axis_hold_ctl", {tx_tlast, tx_tkeep}, {prev_beat.last, prev_beat.keep});
    end
    prev_stall     = tx_tvalid && !tx_tready;
    prev_beat.data = tx_tdata;
    prev_beat.keep = tx_tkeep;
    prev_beat.last = tx_tlast;
    if (hs) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_unexpected: got beat 0x%0h expected no beat", tx_tdata);
      end else begin
        e = exp_q.pop_front();
        chk("tx_data", tx_tdata, e.data);
        chk("tx_ctl", {tx_tlast, tx_tkeep}, {e.last, e.keep});
        if (e.last) exp_tx++;
      end
    end
    if (discarding) chk("in_ready_discard", in_ready, 1);
    if (acc) model_accept();
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input logic dr);
    drv_valid = 1'b1;
    drv_data  = d;
    drv_keep  = k;
    drv_last  = l;
    drv_drop  = dr;
    for (int w = 0; w < 300; w++) begin
      tick();
      if (acc) break;
      stall_cnt++;
    end
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got no accept expected accept within 300 cycles");
    end
    drv_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit drop);
    for (int i = 0; i < len; i++) begin
      if (i == len - 1)
        send_beat(rand64(), 8'($urandom_range(1, 255)), 1'b1, drop);
      else
        send_beat(rand64(), 8'hFF, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic drain();
    drv_valid = 1'b0;
    for (int w = 0; w < 600; w++) begin
      tick();
      if (exp_q.size() == 0 && !tx_tvalid) break;
    end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_occupancy", occupancy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drv_valid = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_tvalid", tx_tvalid, 0);
    chk("rst_tdata", tx_tdata, 0);
    chk("rst_tctl", {tx_tlast, tx_tkeep}, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tx_pkt_cnt", tx_pkt_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    exp_q.delete();
    cur_pkt.delete();
    discarding = 1'b0;
    exp_tx = 0;
    exp_drop = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   tbl_drop;
    int   tbl_tx;
    int   len;
    bit   drop;

    // len, drop, tready mode, drop_cnt increment, tx_pkt_cnt increment, stalls
    tbl.push_back('{4,  1'b1, 0, 1, 0, 0});
    tbl.push_back('{2,  1'b0, 0, 0, 1, 0});
    tbl.push_back('{20, 1'b0, 0, 1, 0, 0});
    tbl.push_back('{16, 1'b0, 0, 0, 1, 0});
    tbl.push_back('{1,  1'b0, 1, 0, 1, 0});
    tbl.push_back('{17, 1'b0, 1, 1, 0, 0});
    tbl.push_back('{16, 1'b1, 3, 1, 0, 0});
    tbl.push_back('{15, 1'b0, 3, 0, 1, 0});
    tbl.push_back('{20, 1'b1, 0, 1, 0, 0});

    do_reset();

    // 3-beat packet: first beat visible exactly one edge after the commit edge.
    tr_mode = 0;
    send_beat(64'h1111111111111111, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h2222222222222222, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h3333333333333333, 8'h0F, 1'b1, 1'b0);
    tick();
    chk("lat_before", tx_tvalid, 0);
    tick();
    chk("lat_first_valid", tx_tvalid, 1);
    chk("lat_first_data", tx_tdata, 64'h1111111111111111);
    drain();
    chk("t1_tx_pkt_cnt", tx_pkt_cnt, 1);
    $display("t1: 3-beat packet tx_pkt_cnt=%0d", tx_pkt_cnt);

    // Table of single packets, each fully drained before the next.
    do_reset();
    tbl_drop = 0;
    tbl_tx = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      tr_mode = v.tmode;
      stall_cnt = 0;
      send_pkt(v.len, v.drop);
      chk("row_stall", stall_cnt, v.exp_stall);
      drain();
      tbl_drop += v.exp_drop_inc;
      tbl_tx += v.exp_tx_inc;
      chk("row_drop_cnt", drop_cnt, tbl_drop);
      chk("row_tx_pkt_cnt", tx_pkt_cnt, tbl_tx);
      $display("row %0d: len=%0d drop=%0d mode=%0d drop_cnt=%0d tx_pkt_cnt=%0d",
               i, v.len, v.drop, v.tmode, drop_cnt, tx_pkt_cnt);
    end

    // Five 5-beat packets into a stalled output: 17 beats fit (16 stored plus
    // one in the output register), the 18th is refused.
    tr_mode = 2;
    stall_cnt = 0;
    for (int g = 0; g < 17; g++) send_beat(rand64(), 8'hFF, (g % 5) == 4, 1'b0);
    chk("t4_no_early_stall", stall_cnt, 0);
    drv_valid = 1'b1;
    drv_data = rand64();
    drv_keep = 8'hFF;
    drv_last = 1'b0;
    drv_drop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_in_ready_low", in_ready, 0);
      chk("t4_occupancy_full", occupancy, 16);
    end
    tr_mode = 0;
    send_beat(drv_data, drv_keep, drv_last, drv_drop);
    for (int g = 18; g < 25; g++) send_beat(rand64(), 8'hFF, (g % 5) == 4, 1'b0);
    drain();
    chk("t4_tx_pkt_cnt", tx_pkt_cnt, exp_tx);
    $display("t4: stalled fill, tx_pkt_cnt=%0d", tx_pkt_cnt);

    // Toggling ready across the pointer wrap.
    do_reset();
    tr_mode = 1;
    for (int p = 0; p < 8; p++) send_pkt(5, 1'b0);
    drain();
    chk("t5_tx_pkt_cnt", tx_pkt_cnt, 8);
    chk("t5_drop_cnt", drop_cnt, 0);
    $display("t5: toggled ready, tx_pkt_cnt=%0d", tx_pkt_cnt);

    // Randomised traffic against the model.
    tr_mode = 3;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 20);
      drop = ($urandom_range(0, 4) == 0);
      send_pkt(len, drop);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    chk("rnd_tx_pkt_cnt", tx_pkt_cnt, exp_tx);
    chk("rnd_drop_cnt", drop_cnt, exp_drop);
    $display("rnd: tx_pkt_cnt=%0d drop_cnt=%0d", tx_pkt_cnt, drop_cnt);

    // Reset while a packet is half written.
    tr_mode = 0;
    for (int g = 0; g < 3; g++) send_beat(rand64(), 8'hFF, 1'b0, 1'b0);
    do_reset();
    send_pkt(2, 1'b0);
    drain();
    chk("t6_tx_pkt_cnt", tx_pkt_cnt, 1);
    chk("t6_drop_cnt", drop_cnt, 0);
    $display("t6: after mid-packet reset tx_pkt_cnt=%0d drop_cnt=%0d", tx_pkt_cnt, drop_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
